// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants, types and helpers for the shift-and-add multiplier sequencer
// that time-shares the ArithmeticLogicUnit.
package alu_mul_sequencer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FS_W   = 5;
    localparam int unsigned FLAG_W = 4;

    localparam logic [FS_W-1:0] FS_PASS_A16 = 5'b10000;
    localparam logic [FS_W-1:0] FS_ADD16    = 5'b10100;
    localparam logic [FS_W-1:0] FS_LSL16    = 5'b11011;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHIFT,
        ST_FLAG,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [FS_W-1:0]   funsel;
        logic              wf;
    } alu_drive_t;

    localparam alu_drive_t ALU_IDLE = '{a: '0, b: '0, funsel: FS_PASS_A16, wf: 1'b0};

    // Work state selected by the remaining multiplier bits.
    function automatic state_e work_state(input logic [DATA_W-1:0] q);
        if (q == '0) begin
            return ST_FLAG;
        end else if (q[0]) begin
            return ST_ADD;
        end
        return ST_SHIFT;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result handshake plus ALU operand/result lanes for the multiplier sequencer.
interface alu_mul_sequencer_if;
    import alu_mul_sequencer_pkg::*;

    logic                start;
    logic [DATA_W-1:0]   multiplicand;
    logic [DATA_W-1:0]   multiplier;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   product;
    logic                overflow;

    logic [DATA_W-1:0]   alu_out;
    logic [FLAG_W-1:0]   flags_out;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [FS_W-1:0]     alu_funsel;
    logic                alu_wf;

    modport master (
        output start, multiplicand, multiplier, alu_out, flags_out,
        input  busy, done, product, overflow, alu_a, alu_b, alu_funsel, alu_wf
    );

    modport slave (
        input  start, multiplicand, multiplier, alu_out, flags_out,
        output busy, done, product, overflow, alu_a, alu_b, alu_funsel, alu_wf
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// 16x16 unsigned shift-and-add multiplier driving a shared ALU; returns the low
// half of the product with an exact overflow flag.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    alu_mul_sequencer_if.slave bus
);

    state_e            r_state, w_state_next;
    logic [DATA_W-1:0] r_m, w_m_next;
    logic [DATA_W-1:0] r_q, w_q_next;
    logic [DATA_W-1:0] r_p, w_p_next;
    logic              r_ovf, w_ovf_next;
    logic              r_prev_add, w_prev_add_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic [DATA_W-1:0] r_product, w_product_next;
    logic              r_overflow, w_overflow_next;
    alu_drive_t        r_alu, w_alu_next;
    logic [DATA_W-1:0] w_q_shr;

    // Next-state, datapath updates, and the ALU drive for the upcoming state.
    always_comb begin
        w_state_next    = r_state;
        w_m_next        = r_m;
        w_q_next        = r_q;
        w_p_next        = r_p;
        w_ovf_next      = r_ovf;
        w_prev_add_next = r_prev_add;
        w_done_next     = 1'b0;
        w_product_next  = r_product;
        w_overflow_next = r_overflow;
        w_alu_next      = ALU_IDLE;
        w_q_shr         = r_q >> 1;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_m_next        = bus.multiplicand;
                    w_q_next        = bus.multiplier;
                    w_p_next        = '0;
                    w_ovf_next      = 1'b0;
                    w_prev_add_next = 1'b0;
                    w_state_next    = work_state(bus.multiplier);
                end
            end
            ST_ADD: begin
                w_p_next        = bus.alu_out;
                w_prev_add_next = 1'b1;
                w_state_next    = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_m_next        = bus.alu_out;
                w_q_next        = w_q_shr;
                w_prev_add_next = 1'b0;
                // Carry out of the last add, or a lost multiplicand bit still to be added.
                if ((r_prev_add && bus.flags_out[FLAG_C]) || (r_m[DATA_W-1] && (w_q_shr != '0))) begin
                    w_ovf_next = 1'b1;
                end
                w_state_next = work_state(w_q_shr);
            end
            ST_FLAG: begin
                w_done_next     = 1'b1;
                w_product_next  = r_p;
                w_overflow_next = r_ovf;
                w_state_next    = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);

        case (w_state_next)
            ST_ADD:   w_alu_next = '{a: w_p_next, b: w_m_next, funsel: FS_ADD16,    wf: 1'b1};
            ST_SHIFT: w_alu_next = '{a: w_m_next, b: '0,       funsel: FS_LSL16,    wf: 1'b0};
            ST_FLAG:  w_alu_next = '{a: w_p_next, b: '0,       funsel: FS_PASS_A16, wf: 1'b1};
            default:  w_alu_next = ALU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_m        <= '0;
            r_q        <= '0;
            r_p        <= '0;
            r_ovf      <= 1'b0;
            r_prev_add <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_alu      <= ALU_IDLE;
        end else begin
            r_state    <= w_state_next;
            r_m        <= w_m_next;
            r_q        <= w_q_next;
            r_p        <= w_p_next;
            r_ovf      <= w_ovf_next;
            r_prev_add <= w_prev_add_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_product  <= w_product_next;
            r_overflow <= w_overflow_next;
            r_alu      <= w_alu_next;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.product    = r_product;
    assign bus.overflow   = r_overflow;
    assign bus.alu_a      = r_alu.a;
    assign bus.alu_b      = r_alu.b;
    assign bus.alu_funsel = r_alu.funsel;
    assign bus.alu_wf     = r_alu.wf;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural ALU attached.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_mul_sequencer_if sif ();

    alu_mul_sequencer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational result, flags registered when WF is high.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, sif.alu_a} + {1'b0, sif.alu_b};
        case (sif.alu_funsel)
            FS_PASS_A16: sif.alu_out = sif.alu_a;
            FS_ADD16:    sif.alu_out = alu_sum[15:0];
            FS_LSL16:    sif.alu_out = {sif.alu_a[14:0], 1'b0};
            default:     sif.alu_out = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sif.flags_out <= 4'b0000;
        end else if (sif.alu_wf) begin
            sif.flags_out[FLAG_Z] <= (sif.alu_out == 16'h0000);
            sif.flags_out[FLAG_N] <= sif.alu_out[15];
            if (sif.alu_funsel == FS_ADD16) begin
                sif.flags_out[FLAG_C] <= alu_sum[16];
                sif.flags_out[FLAG_O] <= (sif.alu_a[15] == sif.alu_b[15]) && (alu_sum[15] != sif.alu_a[15]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply; lat counts cycles from the accepting edge to the Done cycle.
    task automatic run_mul(input logic [15:0] mcand, input logic [15:0] mplier,
                           input int pulse_at, output int lat);
        @(negedge clk);
        check("pre_busy", 32'(sif.busy), 32'h0);
        check("pre_done", 32'(sif.done), 32'h0);
        sif.start        = 1'b1;
        sif.multiplicand = mcand;
        sif.multiplier   = mplier;
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                sif.start        = 1'b0;
                sif.multiplicand = 16'hAAAA;
                sif.multiplier   = 16'h5555;
            end
            if (pulse_at != 0 && lat == pulse_at) begin
                check("busy_at_pulse", 32'(sif.busy), 32'h1);
                sif.start        = 1'b1;
                sif.multiplicand = 16'h0001;
                sif.multiplier   = 16'h0001;
            end
            if (pulse_at != 0 && lat == pulse_at + 1) sif.start = 1'b0;
            if (sif.done) break;
        end
    endtask

    int lat;
    int done_seen;

    initial begin
        rst              = 1'b1;
        sif.start        = 1'b0;
        sif.multiplicand = 16'h0000;
        sif.multiplier   = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(sif.busy),       32'h0);
        check("rst_done",   32'(sif.done),       32'h0);
        check("rst_product", 32'(sif.product),   32'h0);
        check("rst_funsel", 32'(sif.alu_funsel), 32'(FS_PASS_A16));
        check("rst_wf",     32'(sif.alu_wf),     32'h0);
        check("rst_alu_a",  32'(sif.alu_a),      32'h0);

        run_mul(16'h0003, 16'h0005, 0, lat);
        check("3x5_lat",  32'(lat),                    32'd7);
        check("3x5_prod", 32'(sif.product),            32'h000F);
        check("3x5_ovf",  32'(sif.overflow),           32'h0);
        check("3x5_z",    32'(sif.flags_out[FLAG_Z]),  32'h0);
        check("3x5_n",    32'(sif.flags_out[FLAG_N]),  32'h0);

        repeat (2) @(negedge clk);
        run_mul(16'h1234, 16'h0000, 0, lat);
        check("x0_lat",  32'(lat),                   32'd2);
        check("x0_prod", 32'(sif.product),           32'h0000);
        check("x0_ovf",  32'(sif.overflow),          32'h0);
        check("x0_z",    32'(sif.flags_out[FLAG_Z]), 32'h1);

        run_mul(16'h6000, 16'h0003, 0, lat);
        check("carry_lat",  32'(lat),         32'd6);
        check("carry_prod", 32'(sif.product), 32'h2000);
        check("carry_ovf",  32'(sif.overflow), 32'h1);

        run_mul(16'hFFFF, 16'hFFFF, 10, lat);
        check("max_lat",  32'(lat),                   32'd34);
        check("max_prod", 32'(sif.product),           32'h0001);
        check("max_ovf",  32'(sif.overflow),          32'h1);
        check("max_z",    32'(sif.flags_out[FLAG_Z]), 32'h0);

        // Issued in the cycle right after Done: back-to-back acceptance.
        run_mul(16'h0100, 16'h0100, 0, lat);
        check("shout_lat",  32'(lat),                   32'd12);
        check("shout_prod", 32'(sif.product),           32'h0000);
        check("shout_ovf",  32'(sif.overflow),          32'h1);
        check("shout_z",    32'(sif.flags_out[FLAG_Z]), 32'h1);

        // Reset while in SHIFT of a long run.
        @(negedge clk);
        sif.start        = 1'b1;
        sif.multiplicand = 16'hFFFF;
        sif.multiplier   = 16'hFFFF;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(sif.busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy",    32'(sif.busy),       32'h0);
        check("mrst_done",    32'(sif.done),       32'h0);
        check("mrst_ovf",     32'(sif.overflow),   32'h0);
        check("mrst_product", 32'(sif.product),    32'h0);
        check("mrst_funsel",  32'(sif.alu_funsel), 32'(FS_PASS_A16));
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (sif.done || sif.busy) done_seen++;
        end
        check("mrst_no_activity", 32'(done_seen), 32'h0);

        run_mul(16'h0002, 16'h0002, 0, lat);
        check("2x2_lat",  32'(lat),          32'd5);
        check("2x2_prod", 32'(sif.product),  32'h0004);
        check("2x2_ovf",  32'(sif.overflow), 32'h0);

        @(negedge clk);
        check("post_done_low", 32'(sif.done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle 16×16 unsigned shift-and-add multiplier that time-shares the existing ArithmeticLogicUnit rather than owning a multiplier array. It sits directly upstream of the ALU: it drives the ALU's A/B/FunSel/WF inputs each cycle, captures ALUOut and FlagsOut back, and returns the low 16 bits of the product with an exact overflow indication. While busy it has exclusive use of the ALU.

## Interface
- No parameters; widths fixed at 16-bit data, 5-bit FunSel, 4-bit flags {Z,C,N,O}.
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- Start  in  1  request; accepted only in IDLE.
- Multiplicand  in  16  operand latched on accepted Start.
- Multiplier  in  16  operand latched on accepted Start.
- ALUOut  in  16  combinational ALU result.
- FlagsOut  in  4  registered ALU flags {Z,C,N,O}.
- ALU_A, ALU_B  out  16  ALU operands.
- ALU_FunSel  out  5  ALU function select.
- ALU_WF  out  1  ALU flag write enable.
- Busy  out  1  high in every non-IDLE state.
- Done  out  1  one-cycle pulse; Product/Overflow/FlagsOut valid.
- Product  out  16  low 16 bits of result; held until next accepted Start.
- Overflow  out  1  true product ≥ 2^16; held with Product.

## Operation
- Internal regs: M (shifting multiplicand), Q (shifting multiplier), P (partial product), ovf, prev_add.
- States: IDLE, ADD, SHIFT, FLAG, DONE.
- IDLE: drive A=0, B=0, FunSel=10000, WF=0. On Start: M←Multiplicand, Q←Multiplier, P←0, ovf←0; next = Q==0 ? FLAG : Q[0] ? ADD : SHIFT.
- ADD: A=P, B=M, FunSel=10100 (A+B, 16-bit), WF=1; P←ALUOut; prev_add←1; next SHIFT.
- SHIFT: A=M, FunSel=11011 (LSL A, 16-bit), WF=0; M←ALUOut; Q←Q>>1; prev_add←0.
  - ovf set if prev_add and FlagsOut C=1 (carry from preceding add).
  - ovf set if M[15]=1 and (Q>>1)≠0 (shifted-out bit would be added later).
  - next = (Q>>1)==0 ? FLAG : (Q>>1)[0] ? ADD : SHIFT.
- FLAG: A=P, FunSel=10000 (pass A, 16-bit), WF=1 → ALU Z/N reflect product; C/O follow ALU pass-through rule. Next DONE.
- DONE: Done=1, Product←P, Overflow←ovf (visible this cycle); next IDLE.
- Start while Busy ignored; operand inputs ignored except on acceptance.
- Reset at any state: next cycle IDLE; Busy, Done, Product, Overflow, ALU_A, ALU_B, ALU_WF = 0; ALU_FunSel=10000; all internal regs 0.

## Timing
- Start sampled at edge in IDLE; first work state in following cycle.
- Latency (Start edge → Done cycle) = popcount(Multiplier) + (index of MSB set + 1) + 2; Multiplier=0 → 2; max 34 (0xFFFF).
- ADD always followed by SHIFT, including the last set bit.
- Done single cycle; Busy low in Done's following cycle; new Start accepted that cycle (back-to-back).
- FlagsOut valid with Done (written at FLAG→DONE edge).

## Structure
- Shared package: FunSel constants (FS_PASS_A16=10000, FS_ADD16=10100, FS_LSL16=11011), flag bit indices (Z=3, C=2, N=1, O=0), state enum.
- Single module; FSM plus datapath regs, no sub-module. ALU instantiated only in the bench/top, not inside.

## Test plan
- Reset, then idle 3 cycles → Busy=0, Done=0, Product=0, ALU_FunSel=10000, ALU_WF=0.
- 0x0003×0x0005 → states ADD,SHIFT,SHIFT,ADD,SHIFT,FLAG,DONE; Done 7 cycles after Start; Product=0x000F, Overflow=0, Z=0, N=0.
- 0x1234×0x0000 → Done 2 cycles after Start; Product=0x0000, Overflow=0, Z=1.
- 0x6000×0x0003 → carry on second add; Product=0x2000, Overflow=1, latency 6. 0x0100×0x0100 → shifted-out bit; Product=0x0000, Overflow=1, Z=1.
- 0xFFFF×0xFFFF → latency 34, Product=0x0001, Overflow=1; Start pulsed mid-operation has no effect; back-to-back Start in cycle after Done accepted.
- Reset asserted during SHIFT of a 0xFFFF×0xFFFF run → IDLE next cycle, Busy=0, Overflow=0, no Done pulse; following 0x0002×0x0002 yields Product=0x0004.
